// File: rtl/vec_pkg.sv
// Shared definitions for the vector memory stage: lane count, FSM states
// and the lane-counter type used for issue and capture indexing.
package vec_pkg;
  localparam int LANES = 6;

  typedef enum logic [1:0] {
    IDLE,
    STORE,
    LOAD,
    DONE
  } state_t;

  typedef logic [2:0] lane_t;
endpackage

// File: rtl/vec_mem_serializer.sv
// Serializes a 6-lane vector load/store onto an element-wide synchronous
// memory port, one lane per cycle, and gathers load results for writeback.
module vec_mem_serializer
  import vec_pkg::*;
#(
  parameter int N  = 8,
  parameter int AW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                MemWriteE,
  input  logic                MemReadE,
  input  logic [AW-1:0]       BaseAddrE,
  input  logic [5:0][N-1:0]   WriteDataE,
  output logic [AW-1:0]       MemAddr,
  output logic [N-1:0]        MemWData,
  output logic                MemWE,
  output logic                MemRE,
  input  logic [N-1:0]        MemRData,
  output logic                StallM,
  output logic                DoneM,
  output logic [5:0][N-1:0]   ReadDataM
);

  localparam lane_t LAST_LANE = lane_t'(LANES - 1);
  localparam lane_t END_LANE  = lane_t'(LANES);

  state_t                   state;
  lane_t                    cnt;
  logic [AW-1:0]            base;
  logic [LANES-1:0][N-1:0]  wdata;
  logic [LANES-1:0][N-1:0]  cap;
  logic [LANES-1:0][N-1:0]  cap_nxt;
  lane_t                    ptr_p1;
  logic                     vld_p1;
  logic                     issue;

  // Issue stage: memory port decoded from registered state
  assign issue    = (state == STORE) || ((state == LOAD) && (cnt != END_LANE));
  assign MemWE    = (state == STORE);
  assign MemRE    = (state == LOAD) && (cnt != END_LANE);
  assign MemAddr  = issue ? (base + AW'(cnt)) : '0;
  assign MemWData = (state == STORE) ? wdata[cnt] : '0;
  assign StallM   = (state == STORE) || (state == LOAD) ||
                    ((state == IDLE) && (MemWriteE || MemReadE));

  // Capture stage: read data arrives one cycle after its issue
  always_comb begin
    cap_nxt = cap;
    if (vld_p1) cap_nxt[ptr_p1] = MemRData;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      base      <= '0;
      wdata     <= '0;
      cap       <= '0;
      ptr_p1    <= '0;
      vld_p1    <= 1'b0;
      DoneM     <= 1'b0;
      ReadDataM <= '0;
    end else begin
      vld_p1 <= 1'b0;
      DoneM  <= 1'b0;
      cap    <= cap_nxt;
      case (state)
        IDLE: begin
          if (MemWriteE) begin
            base  <= BaseAddrE;
            wdata <= WriteDataE;
            cnt   <= '0;
            state <= STORE;
          end else if (MemReadE) begin
            base  <= BaseAddrE;
            cnt   <= '0;
            state <= LOAD;
          end
        end
        STORE: begin
          if (cnt == LAST_LANE) begin
            cnt   <= '0;
            DoneM <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        LOAD: begin
          // One extra cycle after the last issue lets lane 5 land
          if (cnt != END_LANE) begin
            vld_p1 <= 1'b1;
            ptr_p1 <= cnt;
            cnt    <= cnt + 3'd1;
          end else begin
            ReadDataM <= cap_nxt;
            cnt       <= '0;
            DoneM     <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_mem_serializer.sv
// Directed bench for vec_mem_serializer: transaction-timeline model plus
// memory image, checked every cycle, with literal expectations per scenario.
module tb_vec_mem_serializer;
  localparam int N  = 8;
  localparam int AW = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              MemWriteE, MemReadE;
  logic [AW-1:0]     BaseAddrE;
  logic [5:0][N-1:0] WriteDataE;
  logic [AW-1:0]     MemAddr;
  logic [N-1:0]      MemWData;
  logic              MemWE, MemRE;
  logic [N-1:0]      MemRData;
  logic              StallM, DoneM;
  logic [5:0][N-1:0] ReadDataM;

  vec_mem_serializer #(.N(N), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .MemWriteE(MemWriteE), .MemReadE(MemReadE),
    .BaseAddrE(BaseAddrE), .WriteDataE(WriteDataE), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemWE(MemWE), .MemRE(MemRE), .MemRData(MemRData),
    .StallM(StallM), .DoneM(DoneM), .ReadDataM(ReadDataM)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory attached to the DUT port
  logic [N-1:0] dmem [256];
  int wr_count = 0;
  always @(posedge clk) begin
    if (MemWE) begin
      dmem[MemAddr] = MemWData;
      wr_count++;
    end
    if (MemRE) MemRData <= dmem[MemAddr];
  end

  // Reference model: transaction timeline (t = cycles since accept) and memory image
  int                mode;  // 0 idle, 1 store, 2 load
  int                t;
  logic [AW-1:0]     m_base;
  logic [5:0][N-1:0] m_data;
  logic [5:0][N-1:0] rd_exp;
  logic [N-1:0]      mm [256];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode   = 0;
      t      = 0;
      rd_exp = '0;
    end else if (mode != 0) begin
      if (mode == 1 && t >= 1 && t <= 6) mm[AW'(m_base + AW'(t - 1))] = m_data[t-1];
      if (mode == 2 && t == 7)
        for (int k = 0; k < 6; k++) rd_exp[k] = mm[AW'(m_base + AW'(k))];
      t++;
      if ((mode == 1 && t > 7) || (mode == 2 && t > 8)) mode = 0;
    end else if (MemWriteE || MemReadE) begin
      mode   = MemWriteE ? 1 : 2;
      t      = 1;
      m_base = BaseAddrE;
      m_data = WriteDataE;
    end
  end

  always @(negedge clk) begin
    logic          e_we, e_re, e_done, e_stall;
    logic [AW-1:0] e_addr;
    logic [N-1:0]  e_wd;
    e_we    = (mode == 1) && (t >= 1) && (t <= 6);
    e_re    = (mode == 2) && (t >= 1) && (t <= 6);
    e_done  = (mode == 1 && t == 7) || (mode == 2 && t == 8);
    e_stall = (mode != 0) ? !e_done : (MemWriteE || MemReadE);
    e_addr  = (e_we || e_re) ? AW'(m_base + AW'(t - 1)) : '0;
    e_wd    = e_we ? m_data[t-1] : '0;
    chk("MemWE", 64'(MemWE), 64'(e_we));
    chk("MemRE", 64'(MemRE), 64'(e_re));
    chk("DoneM", 64'(DoneM), 64'(e_done));
    chk("StallM", 64'(StallM), 64'(e_stall));
    chk("ReadDataM", 64'(ReadDataM), 64'(rd_exp));
    if (!(mode == 2 && t == 7)) begin
      chk("MemAddr", 64'(MemAddr), 64'(e_addr));
      chk("MemWData", 64'(MemWData), 64'(e_wd));
    end
  end

  task automatic idle_inputs();
    MemWriteE  = 1'b0;
    MemReadE   = 1'b0;
    BaseAddrE  = '0;
    WriteDataE = '0;
  endtask

  // Present a request for one cycle; returns #1 into cycle 1
  task automatic req(input logic w, input logic r, input logic [AW-1:0] b,
                     input logic [47:0] d);
    MemWriteE  = w;
    MemReadE   = r;
    BaseAddrE  = b;
    WriteDataE = d;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      dmem[a] = N'(a + 1);
      mm[a]   = N'(a + 1);
    end
    rst_n = 1'b0;
    idle_inputs();
    #1;
    // Reset with random request inputs
    for (int i = 0; i < 4; i++) begin
      MemWriteE  = 1'($urandom);
      MemReadE   = 1'($urandom);
      BaseAddrE  = AW'($urandom);
      WriteDataE = 48'({$urandom, $urandom});
      #3;
      chk("rst_MemWE", 64'(MemWE), 64'd0);
      chk("rst_MemAddr", 64'(MemAddr), 64'd0);
      chk("rst_StallM", 64'(StallM), 64'(MemWriteE || MemReadE));
      @(posedge clk); #1;
    end
    idle_inputs();
    #2 rst_n = 1'b1;
    step(1);

    // Store base 0x10
    req(1'b1, 1'b0, 8'h10, 48'h66_55_44_33_22_11);
    step(6);
    chk("store_done", 64'(DoneM), 64'd1);
    chk("store_stall_c7", 64'(StallM), 64'd0);
    step(1);
    for (int k = 0; k < 6; k++) chk("store_mem", 64'(dmem[8'h10 + k]), 64'(8'h11 * (k + 1)));

    // Load across the address wrap
    req(1'b0, 1'b1, 8'hFD, '0);
    step(7);
    chk("wrap_done", 64'(DoneM), 64'd1);
    chk("wrap_rdata", 64'(ReadDataM), 64'h0302_0100_FFFE);
    step(1);

    // Both requests high: store only
    req(1'b1, 1'b1, 8'h20, 48'hF6_E5_D4_C3_B2_A1);
    step(7);
    chk("both_mem0", 64'(dmem[8'h20]), 64'hA1);
    chk("both_mem5", 64'(dmem[8'h25]), 64'hF6);
    chk("both_rdata_held", 64'(ReadDataM), 64'h0302_0100_FFFE);

    // Reset during cycle 3 of a store
    req(1'b1, 1'b0, 8'h40, 48'hA6_A5_A4_A3_A2_A1);
    step(2);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_MemWE", 64'(MemWE), 64'd0);
    chk("abort_StallM", 64'(StallM), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1);
    chk("abort_mem0", 64'(dmem[8'h40]), 64'hA1);
    chk("abort_mem1", 64'(dmem[8'h41]), 64'hA2);
    chk("abort_mem2", 64'(dmem[8'h42]), 64'h43);
    chk("abort_rdata", 64'(ReadDataM), 64'd0);

    // Load after abort
    req(1'b0, 1'b1, 8'h40, '0);
    step(7);
    chk("post_abort_rdata", 64'(ReadDataM), 64'h4645_4443_A2A1);
    step(1);

    // Store request held through DONE, then a load the cycle after
    wr_count   = 0;
    MemWriteE  = 1'b1;
    BaseAddrE  = 8'h60;
    WriteDataE = 48'h0F_0E_0D_0C_0B_0A;
    step(7);
    chk("held_done", 64'(DoneM), 64'd1);
    step(1);
    MemWriteE = 1'b0;
    MemReadE  = 1'b1;
    #1;
    chk("held_accept_stall", 64'(StallM), 64'd1);
    chk("held_no_dup_we", 64'(MemWE), 64'd0);
    @(posedge clk); #1;
    idle_inputs();
    chk("held_load_re", 64'(MemRE), 64'd1);
    chk("held_load_addr", 64'(MemAddr), 64'h60);
    chk("held_wr_count", 64'(wr_count), 64'd6);
    step(7);
    chk("held_rdata", 64'(ReadDataM), 64'h0F0E_0D0C_0B0A);
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
